hdr_pulse_gen: RTL and testbench

//  Multi-channel programmable pulse generator for J3 header/scope outputs (scope trigger, fast RX switch, debug).

---
 rtl/hdr_pulse_gen.sv | 211 +++++++++++++++++++++
 tb/tb_hdr_pulse_gen.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hdr_pulse_gen.sv
// hdr_pulse_gen: NUM_CH programmable delay/width/polarity pulse outputs launched by trig_in or sw_trig.
// Define HDR_PULSE_REPEAT_EN to build the per-channel burst repeat (GAP state, cfg_per, cfg_rpt).
//
// state  | meaning
// IDLE   | waiting for an accepted event, output at inactive level
// DELAY  | counting down the latched delay
// ACTIVE | output asserted for the latched width
// GAP    | inactive spacing before the next repeat (repeat build only)
module hdr_pulse_gen #(
    parameter int NUM_CH      = 3,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    trig_in,
    input  logic                    sw_trig,
    input  logic                    arm,
    input  logic                    clr,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [NUM_CH-1:0]       cfg_pol,
    input  logic [NUM_CH*CNT_W-1:0] cfg_dly,
    input  logic [NUM_CH*CNT_W-1:0] cfg_wid,
    input  logic [NUM_CH*CNT_W-1:0] cfg_per,
    input  logic [7:0]              cfg_rpt,
    output logic [NUM_CH-1:0]       pulse_out,
    output logic                    busy,
    output logic [31:0]             trig_cnt,
    output logic                    overrun
);

`ifdef HDR_PULSE_REPEAT_EN
    typedef enum logic [1:0] {IDLE, DELAY, ACTIVE, GAP} ch_state_t;
`else
    typedef enum logic [1:0] {IDLE, DELAY, ACTIVE} ch_state_t;
`endif

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   trig_d_q;
    logic                   rise_q;
    logic                   evt;
    logic                   accept;
    logic                   any_busy;
    logic [NUM_CH-1:0]      ch_busy;
    logic [NUM_CH-1:0]      pulse_d;

    // trig_in is asynchronous; the registered rise keeps evt glitch-free
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q   <= '0;
            trig_d_q <= 1'b0;
            rise_q   <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], trig_in};
            trig_d_q <= sync_q[SYNC_STAGES-1];
            rise_q   <= sync_q[SYNC_STAGES-1] & ~trig_d_q;
        end
    end

    assign evt      = (rise_q | sw_trig) & arm;
    assign any_busy = |ch_busy;
    assign accept   = evt & ~any_busy;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            trig_cnt  <= '0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
            pulse_out <= '0;
        end else begin
            if (clr)
                trig_cnt <= '0;
            else if (accept)
                trig_cnt <= trig_cnt + 32'd1;

            if (evt && any_busy)
                overrun <= 1'b1;
            else if (clr)
                overrun <= 1'b0;

            busy      <= any_busy;
            pulse_out <= pulse_d;
        end
    end

`ifndef HDR_PULSE_REPEAT_EN
    logic unused_cfg;
    assign unused_cfg = ^{cfg_per, cfg_rpt};
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] dly_cfg;
        logic [CNT_W-1:0] wid_cfg;
        logic             start;
        ch_state_t        state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] wid_q, wid_d;
        logic             lvl;
        logic             not_idle;
`ifdef HDR_PULSE_REPEAT_EN
        logic [CNT_W-1:0] per_cfg;
        logic [CNT_W-1:0] per_q, per_d;
        logic [CNT_W-1:0] gap_ld;
        logic [7:0]       rpt_q, rpt_d;

        assign per_cfg = cfg_per[i*CNT_W +: CNT_W];
        // per is start-to-start; a period no longer than the width still leaves one idle cycle
        assign gap_ld  = (per_q > wid_q) ? (per_q - wid_q - CNT_ONE) : '0;
`endif

        assign dly_cfg = cfg_dly[i*CNT_W +: CNT_W];
        assign wid_cfg = cfg_wid[i*CNT_W +: CNT_W];
        assign start   = accept & ch_en[i] & (wid_cfg != '0);

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                wid_q   <= '0;
`ifdef HDR_PULSE_REPEAT_EN
                per_q   <= '0;
                rpt_q   <= '0;
`endif
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                wid_q   <= wid_d;
`ifdef HDR_PULSE_REPEAT_EN
                per_q   <= per_d;
                rpt_q   <= rpt_d;
`endif
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            wid_d   = wid_q;
`ifdef HDR_PULSE_REPEAT_EN
            per_d   = per_q;
            rpt_d   = rpt_q;
`endif
            case (state_q)
                IDLE: begin
                    if (start) begin
                        wid_d = wid_cfg;
`ifdef HDR_PULSE_REPEAT_EN
                        per_d = per_cfg;
                        rpt_d = cfg_rpt;
`endif
                        if (dly_cfg == '0) begin
                            state_d = ACTIVE;
                            cnt_d   = wid_cfg - CNT_ONE;
                        end else begin
                            state_d = DELAY;
                            cnt_d   = dly_cfg - CNT_ONE;
                        end
                    end
                end
                DELAY: begin
                    if (cnt_q == '0) begin
                        state_d = ACTIVE;
                        cnt_d   = wid_q - CNT_ONE;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                ACTIVE: begin
                    if (cnt_q == '0) begin
`ifdef HDR_PULSE_REPEAT_EN
                        if (rpt_q != '0) begin
                            state_d = GAP;
                            cnt_d   = gap_ld;
                            rpt_d   = rpt_q - 8'd1;
                        end else begin
                            state_d = IDLE;
                        end
`else
                        state_d = IDLE;
`endif
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
`ifdef HDR_PULSE_REPEAT_EN
                GAP: begin
                    if (cnt_q == '0) begin
                        state_d = ACTIVE;
                        cnt_d   = wid_q - CNT_ONE;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
        end

        // polarity is applied live so a change lands on the next edge, even mid-pulse
        always_comb begin
            lvl      = (state_q == ACTIVE) ^ cfg_pol[i];
            not_idle = (state_q != IDLE);
        end

        assign pulse_d[i] = lvl;
        assign ch_busy[i] = not_idle;
    end

endmodule

// File: tb/tb_hdr_pulse_gen.sv
// Bench for hdr_pulse_gen: directed stimulus pushes expected pulse_out transitions, a monitor pops them.
// Status outputs (busy, trig_cnt, overrun) are compared directly against hand-computed values.
module tb_hdr_pulse_gen;
    localparam int N = 3;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rstn;
    logic           trig_in, sw_trig, arm, clr;
    logic [N-1:0]   ch_en, cfg_pol;
    logic [N*W-1:0] cfg_dly, cfg_wid, cfg_per;
    logic [7:0]     cfg_rpt;
    logic [N-1:0]   pulse_out;
    logic           busy;
    logic [31:0]    trig_cnt;
    logic           overrun;

    hdr_pulse_gen #(.NUM_CH(N), .CNT_W(W), .SYNC_STAGES(2)) dut (
        .clk(clk), .rstn(rstn), .trig_in(trig_in), .sw_trig(sw_trig), .arm(arm), .clr(clr),
        .ch_en(ch_en), .cfg_pol(cfg_pol), .cfg_dly(cfg_dly), .cfg_wid(cfg_wid),
        .cfg_per(cfg_per), .cfg_rpt(cfg_rpt), .pulse_out(pulse_out), .busy(busy),
        .trig_cnt(trig_cnt), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           cyc;
        logic [N-1:0] val;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         ev;
    int           cyc = 0;
    int           n_total = 0;
    int           n_pass = 0;
    logic [N-1:0] last_po = '0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (pulse_out !== last_po) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL pulse_edge unexpected: cyc=%0d got=%b required=no change", cyc, pulse_out);
            end else begin
                ev = exp_q.pop_front();
                if (ev.cyc == cyc && ev.val === pulse_out)
                    n_pass++;
                else
                    $display("FAIL pulse_edge: got cyc=%0d val=%b required cyc=%0d val=%b",
                             cyc, pulse_out, ev.cyc, ev.val);
            end
            last_po = pulse_out;
        end
    end

    function automatic void push(input int c, input logic [N-1:0] v);
        exp_t e;
        e.cyc = c;
        e.val = v;
        exp_q.push_back(e);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got=%0h required=%0h (cyc=%0d)", name, act, req, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) tick(1);
    endtask

    task automatic set_ch(input int i, input int dly, input int wid, input int per);
        cfg_dly[i*W +: W] = W'(dly);
        cfg_wid[i*W +: W] = W'(wid);
        cfg_per[i*W +: W] = W'(per);
    endtask

    task automatic fire();
        sw_trig = 1'b1;
        tick(1);
        sw_trig = 1'b0;
    endtask

    int e;

    initial begin
        rstn = 1'b1; trig_in = 1'b0; sw_trig = 1'b0; arm = 1'b1; clr = 1'b0;
        ch_en = 3'b001; cfg_pol = 3'b000; cfg_dly = '0; cfg_wid = '0; cfg_per = '0; cfg_rpt = '0;
        set_ch(0, 3, 5, 0);
        #2 rstn = 1'b0;
        #1;
        chk("reset_pulse_out", 32'(pulse_out), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_trig_cnt", trig_cnt, 32'd0);
        chk("reset_overrun", 32'(overrun), 32'd0);
        tick(2);
        rstn = 1'b1;

        // dly=3 wid=5: high evt+5..evt+9; config changed mid-flight must not matter
        wait_cyc(10);
        e = cyc;
        push(e + 5, 3'b001); push(e + 10, 3'b000);
        fire();
        set_ch(0, 0, 9, 0);
        wait_cyc(e + 5);
        chk("t1_busy_mid", 32'(busy), 32'd1);
        wait_cyc(e + 11);
        chk("t1_busy_end", 32'(busy), 32'd0);
        chk("t1_trig_cnt", trig_cnt, 32'd1);
        set_ch(0, 3, 5, 0);
        clr = 1'b1; tick(1); clr = 1'b0;
        chk("clr_trig_cnt", trig_cnt, 32'd0);

        // event while busy is dropped; clr with busy event leaves overrun set
        e = cyc;
        push(e + 5, 3'b001); push(e + 10, 3'b000);
        fire();
        wait_cyc(e + 2);
        fire();
        chk("t3_overrun", 32'(overrun), 32'd1);
        chk("t3_trig_cnt", trig_cnt, 32'd1);
        clr = 1'b1; tick(1); clr = 1'b0;
        chk("t3_clr_cnt", trig_cnt, 32'd0);
        chk("t3_clr_ovr", 32'(overrun), 32'd0);
        wait_cyc(e + 6);
        sw_trig = 1'b1; clr = 1'b1; tick(1); sw_trig = 1'b0; clr = 1'b0;
        chk("clr_vs_busy_evt_ovr", 32'(overrun), 32'd1);
        chk("clr_vs_busy_evt_cnt", trig_cnt, 32'd0);
        wait_cyc(e + 12);
        clr = 1'b1; tick(1); clr = 1'b0;
        chk("t3_final_ovr", 32'(overrun), 32'd0);

        // accepted event with no channel enabled still counts; clr wins over accept
        ch_en = 3'b000;
        fire();
        chk("noch_trig_cnt", trig_cnt, 32'd1);
        tick(1);
        chk("noch_busy", 32'(busy), 32'd0);
        sw_trig = 1'b1; clr = 1'b1; tick(1); sw_trig = 1'b0; clr = 1'b0;
        chk("clr_vs_accept_cnt", trig_cnt, 32'd0);

        // trig_in path: dly=0 wid=1, pulse 5 cycles after the rise
        ch_en = 3'b001;
        set_ch(0, 0, 1, 0);
        tick(1);
        e = cyc;
        trig_in = 1'b1;
        push(e + 5, 3'b001); push(e + 6, 3'b000);
        wait_cyc(e + 8);
        chk("t2_trig_cnt", trig_cnt, 32'd1);
        trig_in = 1'b0;
        tick(5);
        arm = 1'b0;
        trig_in = 1'b1;
        tick(1);
        fire();
        tick(8);
        chk("t2_disarm_cnt", trig_cnt, 32'd1);
        chk("t2_disarm_ovr", 32'(overrun), 32'd0);
        trig_in = 1'b0;
        arm = 1'b1;
        tick(5);

        // three channels, ch1 wid=0 never pulses, ch2 active-low
        set_ch(0, 0, 4, 0); set_ch(1, 10, 0, 0); set_ch(2, 20, 2, 0);
        ch_en = 3'b111;
        cfg_pol = 3'b100;
        push(cyc + 1, 3'b100);
        tick(2);
        e = cyc;
        push(e + 2, 3'b101); push(e + 6, 3'b100); push(e + 22, 3'b000); push(e + 24, 3'b100);
        fire();
        wait_cyc(e + 26);
        chk("t4_trig_cnt", trig_cnt, 32'd2);

        // async reset mid-ACTIVE
        ch_en = 3'b001;
        set_ch(0, 0, 8, 0);
        e = cyc;
        push(e + 2, 3'b101);
        fire();
        wait_cyc(e + 4);
        push(e + 4, 3'b000);
        rstn = 1'b0;
        #1;
        chk("t5_rst_pulse_out", 32'(pulse_out), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_trig_cnt", trig_cnt, 32'd0);
        tick(2);
        rstn = 1'b1;
        push(e + 7, 3'b100);
        wait_cyc(e + 9);
        chk("t5_post_rst_level", 32'(pulse_out), 32'd4);

        // repeat: dly=0 wid=2 per=6 rpt=2
        cfg_pol = 3'b000;
        push(cyc + 1, 3'b000);
        set_ch(0, 0, 2, 6);
        cfg_rpt = 8'd2;
        tick(2);
        e = cyc;
`ifdef HDR_PULSE_REPEAT_EN
        push(e + 2, 3'b001); push(e + 4, 3'b000);
        push(e + 8, 3'b001); push(e + 10, 3'b000);
        push(e + 14, 3'b001); push(e + 16, 3'b000);
`else
        push(e + 2, 3'b001); push(e + 4, 3'b000);
`endif
        fire();
        wait_cyc(e + 12);
`ifdef HDR_PULSE_REPEAT_EN
        chk("t6_busy_mid", 32'(busy), 32'd1);
`else
        chk("t6_busy_mid", 32'(busy), 32'd0);
`endif
        wait_cyc(e + 18);
        chk("t6_busy_end", 32'(busy), 32'd0);
        chk("t6_trig_cnt", trig_cnt, 32'd1);

        // per <= wid collapses the gap to one cycle
        set_ch(0, 0, 3, 2);
        cfg_rpt = 8'd1;
        e = cyc;
`ifdef HDR_PULSE_REPEAT_EN
        push(e + 2, 3'b001); push(e + 5, 3'b000); push(e + 6, 3'b001); push(e + 9, 3'b000);
`else
        push(e + 2, 3'b001); push(e + 5, 3'b000);
`endif
        fire();
        wait_cyc(e + 14);
        chk("t7_trig_cnt", trig_cnt, 32'd2);
        chk("t7_busy_end", 32'(busy), 32'd0);

        n_total++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL pulse_edge_missing: got %0d pending transitions required 0 (next cyc=%0d)",
                      exp_q.size(), exp_q[0].cyc);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
